// File: rtl/regfile_scan_tx.sv
// -----------------------------------------------------------------------------
// regfile_scan_tx
//
// Dumps a contiguous range of register-file entries onto a byte stream.
// On a start pulse it drives test_addr from FIRST_REG to LAST_REG. At each
// address it waits SETTLE_CYCLES cycles, captures test_data, and sends a
// 5-byte record over a valid/ready interface:
//   {3'b000, index}, data[31:24], data[23:16], data[15:8], data[7:0]
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   begin a scan (sampled only while idle)
//   busy       out  1   high while a scan is in progress
//   done       out  1   one-cycle pulse after the final byte is accepted
//   test_addr  out  5   register-file test port address (registered)
//   test_data  in   32  register-file test port read data (combinational)
//   tx_data    out  8   stream byte
//   tx_valid   out  1   stream byte valid
//   tx_ready   in   1   sink ready; a transfer happens on tx_valid & tx_ready
// -----------------------------------------------------------------------------
module regfile_scan_tx #(
  parameter int FIRST_REG     = 1,
  parameter int LAST_REG      = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  test_addr,
  input  logic [31:0] test_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  // Reject an illegal register range or settle time while elaborating.
  generate
    if ((FIRST_REG < 0) || (FIRST_REG > LAST_REG) || (LAST_REG > 31)) begin : g_bad_range
      $error("regfile_scan_tx: need 0 <= FIRST_REG <= LAST_REG <= 31");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("regfile_scan_tx: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  logic [1:0]       r_state;
  // 6 bits so that the compare against LAST_REG never sees a wrapped index.
  logic [5:0]       r_reg_idx;
  logic [CNT_W-1:0] r_settle_cnt;
  logic [2:0]       r_byte_cnt;
  logic [31:0]      r_shadow;
  logic [4:0]       r_test_addr;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_xfer;
  logic             w_settle_last;
  logic             w_last_reg;
  logic             w_last_byte;
  logic [7:0]       w_lane [0:3];
  logic [7:0]       w_next_byte;

  // Data lanes of the captured word, most significant byte first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = r_shadow[31 - 8*gi -: 8];
    end
  endgenerate

  assign w_xfer        = r_tx_valid & tx_ready;
  assign w_settle_last = (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_last_reg    = (r_reg_idx == 6'(LAST_REG));
  assign w_last_byte   = (r_byte_cnt == 3'd4);
  // After byte b (0..3) is accepted, byte b+1 comes from lane b.
  assign w_next_byte   = w_lane[r_byte_cnt[1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_reg_idx    <= '0;
      r_settle_cnt <= '0;
      r_byte_cnt   <= '0;
      r_shadow     <= '0;
      r_test_addr  <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_reg_idx    <= 6'(FIRST_REG);
            r_test_addr  <= 5'(FIRST_REG);
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (w_settle_last) begin
            // Capture and present the index byte on the same edge.
            r_shadow   <= test_data;
            r_tx_data  <= {3'b000, r_reg_idx[4:0]};
            r_tx_valid <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= ST_SEND;
          end else begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
          end
        end

        ST_SEND: begin
          if (w_xfer) begin
            if (!w_last_byte) begin
              r_tx_data  <= w_next_byte;
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end else begin
              r_tx_valid <= 1'b0;
              if (w_last_reg) begin
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_test_addr <= '0;
                r_state     <= ST_IDLE;
              end else begin
                r_reg_idx    <= r_reg_idx + 6'd1;
                r_test_addr  <= r_reg_idx[4:0] + 5'd1;
                r_settle_cnt <= '0;
                r_state      <= ST_SETTLE;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign test_addr = r_test_addr;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;

endmodule
